// File: rtl/sync_memory_if.sv
// Bus bundle for sync_memory: shared address, write data, write/read select and read data.
interface sync_memory_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 8
);
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] wdata;
    logic             wrbar;
    logic [WIDTH-1:0] rdata;

    modport master (
        output addr,
        output wdata,
        output wrbar,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wrbar,
        output rdata
    );
endinterface

// File: rtl/sync_memory.sv
// Single-port synchronous RAM with registered, one-cycle-latency read data.
// Optional macro SYNC_MEMORY_MEM_CLEAR_EN: reset also zeroes every array location.
module sync_memory #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int ADDR  = 8
) (
    input  logic          clk,
    input  logic          rst,
    sync_memory_if.slave  bus
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic             w_in_range;

    // Extra MSB keeps the compare valid when DEPTH == 2**ADDR.
    assign w_in_range = ({1'b0, bus.addr} < (ADDR+1)'(DEPTH));

`ifdef SYNC_MEMORY_MEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.wrbar && w_in_range) begin
            r_mem[bus.addr] <= bus.wdata;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst && bus.wrbar && w_in_range) begin
            r_mem[bus.addr] <= bus.wdata;
        end
    end
`endif

    // rdata only changes on reads or reset; write cycles leave it holding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (!bus.wrbar) begin
            r_rdata <= w_in_range ? r_mem[bus.addr] : '0;
        end
    end

    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_sync_memory.sv
// Directed self-checking bench for sync_memory (default 32 x 256 configuration).
module tb_sync_memory;
    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int ADDR  = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [WIDTH-1:0] exp_mem [DEPTH];
    logic [WIDTH-1:0] exp_rd;

    sync_memory_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    sync_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] act,
                            input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Present one operation, clock it, then settle 1ns past the edge for sampling.
    task automatic cycle(input logic rst_n, input logic wr, input logic [ADDR-1:0] a,
                         input logic [WIDTH-1:0] d);
        rst       = rst_n;
        bus.wrbar = wr;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        bus.wrbar = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset held for two edges
        cycle(1'b0, 1'b0, 8'h00, 32'h0);
        check_eq("reset_edge1", bus.rdata, 32'h0);
        cycle(1'b0, 1'b0, 8'h00, 32'h0);
        check_eq("reset_edge2", bus.rdata, 32'h0);

        // Full sweep: random writes then read-back
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = $urandom;
            cycle(1'b1, 1'b1, ADDR'(i), exp_mem[i]);
            if (i == 0) check_eq("sweep_write_holds", bus.rdata, 32'h0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, ADDR'(i), 32'h0);
            check_eq($sformatf("sweep_rd_%0d", i), bus.rdata, exp_mem[i]);
        end
        exp_rd = exp_mem[DEPTH-1];

        // Write then immediate read of the same address
        cycle(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        exp_mem[8'h10] = 32'hDEADBEEF;
        check_eq("wr_no_writethrough", bus.rdata, exp_rd);
        cycle(1'b1, 1'b0, 8'h10, 32'h0);
        check_eq("wr_then_rd", bus.rdata, 32'hDEADBEEF);

        // Overwrite at top address, then read a zeroed location
        cycle(1'b1, 1'b1, 8'hFF, 32'h11111111);
        cycle(1'b1, 1'b1, 8'hFF, 32'h22222222);
        cycle(1'b1, 1'b0, 8'hFF, 32'h0);
        check_eq("overwrite_ff", bus.rdata, 32'h22222222);
        cycle(1'b1, 1'b1, 8'h00, 32'h0);
        cycle(1'b1, 1'b0, 8'h00, 32'h0);
        check_eq("read_zero_00", bus.rdata, 32'h0);

        // Reset in the same cycle as a write: write must be aborted
        cycle(1'b1, 1'b1, 8'h05, 32'h5A5A0505);
        cycle(1'b1, 1'b0, 8'h05, 32'h0);
        check_eq("pre_reset_rd5", bus.rdata, 32'h5A5A0505);
        cycle(1'b0, 1'b1, 8'h05, 32'hCAFEF00D);
        check_eq("mid_reset_rdata", bus.rdata, 32'h0);
        cycle(1'b1, 1'b0, 8'h05, 32'h0);
`ifdef SYNC_MEMORY_MEM_CLEAR_EN
        check_eq("post_reset_rd5", bus.rdata, 32'h0);
        cycle(1'b1, 1'b0, 8'hFF, 32'h0);
        check_eq("post_reset_rdff", bus.rdata, 32'h0);
`else
        check_eq("post_reset_rd5", bus.rdata, 32'h5A5A0505);
        cycle(1'b1, 1'b0, 8'hFF, 32'h0);
        check_eq("post_reset_rdff", bus.rdata, 32'h22222222);
`endif

        // Hold: rdata keeps last read value across consecutive writes
        cycle(1'b1, 1'b1, 8'h03, 32'hA5A5A5A5);
        cycle(1'b1, 1'b0, 8'h03, 32'h0);
        check_eq("hold_rd3", bus.rdata, 32'hA5A5A5A5);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, ADDR'(8'h03 + k), 32'h0F0F0000 + k);
            check_eq($sformatf("hold_wr_%0d", k), bus.rdata, 32'hA5A5A5A5);
        end
        cycle(1'b1, 1'b0, 8'h03, 32'h0);
        check_eq("hold_rd3_new", bus.rdata, 32'h0F0F0000);
        cycle(1'b1, 1'b0, 8'h06, 32'h0);
        check_eq("hold_rd6_new", bus.rdata, 32'h0F0F0003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_memory.md
Name: sync_memory

Overview:
- Single-port synchronous RAM, DEPTH words of WIDTH bits, one shared address bus.
- Write/read select via a single control line (wrbar).
- Registered read data, one-cycle latency.
- Generic storage block, sits behind a simple controller or bench driver.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 256, number of words; must be >= 1 and <= 2**ADDR.
- ADDR, 8, address width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-low (rst=0 resets on next rising clk edge).
- addr  input  ADDR  word address for both write and read.
- wdata  input  WIDTH  write data.
- wrbar  input  1  operation select: 1 = write, 0 = read.
- rdata  output  WIDTH  registered read data.

Behaviour:
- Reset: rst=0 at a rising edge sets rdata to 0; no write occurs that cycle.
- Reset and memory contents: without the optional feature, array contents are untouched by reset.
- Reset has priority over wrbar/addr. A reset mid-operation aborts that cycle's access; the next cycle with rst=1 resumes normally.
- Write: rst=1 and wrbar=1 at a rising edge stores wdata into mem[addr].
  - rdata holds its previous value during write cycles (no write-through).
- Read: rst=1 and wrbar=0 at a rising edge sets rdata to mem[addr].
  - rdata is valid after that edge, i.e. one-cycle latency.
  - rdata holds the value until the next read or reset.
- Out-of-range address (only possible when DEPTH < 2**ADDR):
  - Writes to addr >= DEPTH are ignored.
  - Reads from addr >= DEPTH return 0.
- Unwritten locations read X in simulation (no implicit init) unless MEM_CLEAR_EN is defined.
- Back-to-back operations, one per cycle, with no bubbles.
  - A read immediately after a write to the same address returns the newly written data.
- X/Z on wrbar is not a defined operation; the bench must keep wrbar driven whenever rst=1.
- Single port: no simultaneous read/write conflicts exist by construction.

Optional Feature:
- Macro: SYNC_MEMORY_MEM_CLEAR_EN.
- Defined: a reset cycle (rst=0 at a rising edge) also clears every location mem[0..DEPTH-1] to 0 in that same cycle. Subsequent reads of unwritten locations return 0.
- Not defined: reset clears only rdata; array contents are preserved across reset.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wrbar=0, addr=0 -> rdata=0 after the first edge and held.
- Full sweep: write addr i = 0..255 with wdata=random (wrbar=1, one per cycle), then read i = 0..255 (wrbar=0) -> rdata equals the stored word, one cycle after each read address is presented.
- Write-then-read same address: write 0xDEADBEEF to addr 0x10, next cycle read 0x10 -> rdata=0xDEADBEEF after that edge. rdata unchanged during the write cycle.
- Overwrite: write 0x11111111 then 0x22222222 to addr 0xFF, then read -> rdata=0x22222222. Read addr 0x00 (previously 0x0) -> rdata=0x00000000.
- Reset mid-stream: assert rst=0 in the same cycle as a write of 0xCAFEF00D to addr 5, then read addr 5 -> previous contents returned (not 0xCAFEF00D), and rdata=0 during reset. With SYNC_MEMORY_MEM_CLEAR_EN defined -> read returns 0.
- Hold: after reading addr 3 (=0xA5A5A5A5), issue writes for 4 cycles -> rdata stays 0xA5A5A5A5.
